// File: rtl/gray_ptr_pkg.sv
// gray_ptr_pkg
// Shared constants and pointer helpers for the async-FIFO pointer crossing.
// The helpers operate on a MAX_W-wide container. Callers zero-extend their
// pointer into it and truncate the result. Gray<->binary conversion and
// popcount are unaffected by zero-extension, so one set of functions serves
// every pointer width up to MAX_W.
package gray_ptr_pkg;

    localparam int MODE_WR = 0;
    localparam int MODE_RD = 1;

    localparam int MAX_W = 16;

    typedef logic [MAX_W-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input ptr_max_t v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_ptr_sync_cmp_sync_chain.sv
// sync_chain
// Plain multi-flop synchroniser: STAGES back-to-back registers, no logic in
// between, all cleared by the asynchronous active-low reset.
// Ports:
//   clk   destination clock
//   rst   asynchronous, active-low reset
//   din   asynchronous input bus (Gray-coded, so at most one bit moves)
//   dout  last stage
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync_cmp.sv
// gray_ptr_sync_cmp
// Destination-domain half of an async FIFO pointer crossing. The remote Gray
// pointer is synchronised, converted to binary and compared with the local
// binary pointer to give occupancy and full/empty/almost flags. Until the
// synchroniser has flushed its reset contents the flags block conservatively.
// Sticky integrity flags catch multi-bit Gray steps and impossible levels.
// Ports:
//   clk              destination clock
//   rst              asynchronous, active-low reset
//   remote_ptr_gray  Gray pointer from the other domain
//   local_ptr_bin    local binary pointer (clk domain)
//   err_clr          synchronous clear of gray_err / ptr_err
//   sync_ptr_gray    last synchroniser stage
//   sync_ptr_bin     registered binary of sync_ptr_gray
//   level            occupancy (0 while not ready)
//   full             write side only
//   empty            read side only
//   almost           almost-full (write side) / almost-empty (read side)
//   sync_ready       synchroniser warmed up
//   gray_err         sticky Gray step violation
//   ptr_err          sticky level > DEPTH
module gray_ptr_sync_cmp
    import gray_ptr_pkg::*;
#(
    parameter int PTR_SZ      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0,
    parameter int ALMOST_TH   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PTR_SZ:0] remote_ptr_gray,
    input  logic [PTR_SZ:0] local_ptr_bin,
    input  logic            err_clr,
    output logic [PTR_SZ:0] sync_ptr_gray,
    output logic [PTR_SZ:0] sync_ptr_bin,
    output logic [PTR_SZ:0] level,
    output logic            full,
    output logic            empty,
    output logic            almost,
    output logic            sync_ready,
    output logic            gray_err,
    output logic            ptr_err
);

    localparam int PW    = PTR_SZ + 1;
    localparam int DEPTH = 2 ** PTR_SZ;

    localparam logic [PW-1:0] DEPTH_V   = PW'(DEPTH);
    localparam logic [PW-1:0] WR_TH_V   = PW'(DEPTH - ALMOST_TH);
    localparam logic [PW-1:0] RD_TH_V   = PW'(ALMOST_TH);
    localparam logic [2:0]    READY_CNT = 3'(SYNC_STAGES + 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("gray_ptr_sync_cmp: SYNC_STAGES must be 2..4");
    end
    if (MODE != MODE_WR && MODE != MODE_RD) begin : g_bad_mode
        $error("gray_ptr_sync_cmp: MODE must be 0 or 1");
    end
    if (ALMOST_TH < 0 || ALMOST_TH > DEPTH) begin : g_bad_th
        $error("gray_ptr_sync_cmp: ALMOST_TH must be 0..DEPTH");
    end
    if (PW > MAX_W) begin : g_bad_width
        $error("gray_ptr_sync_cmp: pointer wider than package MAX_W");
    end

    logic [PW-1:0] bin_q;
    logic [PW-1:0] gray_prev_q;
    logic [2:0]    wu_cnt_q;
    logic          gray_err_q;
    logic          ptr_err_q;
    logic [PW-1:0] raw_level;
    logic          gray_set;
    logic          ptr_set;

    sync_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (remote_ptr_gray),
        .dout (sync_ptr_gray)
    );

    assign sync_ready = (wu_cnt_q == READY_CNT);

    // Difference is taken modulo 2**PW; the extra MSB lets a full FIFO
    // (difference DEPTH) be told apart from an empty one (difference 0).
    always_comb begin
        raw_level = local_ptr_bin - bin_q;
        if (MODE == MODE_RD) begin
            raw_level = bin_q - local_ptr_bin;
        end
    end

    // A legal crossing moves at most one Gray bit per destination cycle.
    assign gray_set = sync_ready &&
                      (popcount(ptr_max_t'(gray_prev_q ^ sync_ptr_gray)) > 1);
    assign ptr_set  = sync_ready && (raw_level > DEPTH_V);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q       <= '0;
            gray_prev_q <= '0;
            wu_cnt_q    <= '0;
            gray_err_q  <= 1'b0;
            ptr_err_q   <= 1'b0;
        end else begin
            bin_q       <= PW'(gray2bin(ptr_max_t'(sync_ptr_gray)));
            gray_prev_q <= sync_ptr_gray;
            if (wu_cnt_q != READY_CNT) begin
                wu_cnt_q <= wu_cnt_q + 3'd1;
            end
            // A new violation in the clearing cycle must not be lost.
            gray_err_q <= gray_set | (gray_err_q & ~err_clr);
            ptr_err_q  <= ptr_set  | (ptr_err_q  & ~err_clr);
        end
    end

    // Before warm-up the chain still holds reset zeros, so report a state
    // that stops the local side from writing (full) or reading (empty).
    always_comb begin
        level  = '0;
        full   = 1'b0;
        empty  = 1'b0;
        almost = 1'b1;
        if (MODE == MODE_WR) begin
            full = 1'b1;
        end else begin
            empty = 1'b1;
        end
        if (sync_ready) begin
            level = raw_level;
            if (MODE == MODE_WR) begin
                full   = (raw_level == DEPTH_V);
                almost = (raw_level >= WR_TH_V);
            end else begin
                empty  = (raw_level == '0);
                almost = (raw_level <= RD_TH_V);
            end
        end
    end

    assign sync_ptr_bin = bin_q;
    assign gray_err     = gray_err_q;
    assign ptr_err      = ptr_err_q;

endmodule

// File: tb/tb_gray_ptr_sync_cmp.sv
module tb_gray_ptr_sync_cmp;

    localparam int PTR_SZ = 2;
    localparam int S      = 2;
    localparam int ATH    = 1;
    localparam int PW     = PTR_SZ + 1;
    localparam int DEPTH  = 1 << PTR_SZ;
    localparam int MASK   = (1 << PW) - 1;

    typedef struct packed {
        logic [PW-1:0] sg;
        logic [PW-1:0] sb;
        logic [PW-1:0] lvl;
        logic          full;
        logic          empty;
        logic          almost;
        logic          ready;
        logic          gerr;
        logic          perr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          err_clr = 1'b0;
    logic [PW-1:0] remote = '0;
    logic [PW-1:0] local_b = '0;

    logic [PW-1:0] w_sg, w_sb, w_lvl, r_sg, r_sb, r_lvl;
    logic          w_full, w_empty, w_almost, w_ready, w_gerr, w_perr;
    logic          r_full, r_empty, r_almost, r_ready, r_gerr, r_perr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: history of remote values captured at each edge
    // (newest first), edges since reset release, sticky flags.
    int   hist[$];
    int   edges;
    bit   gerr;
    bit   perr [2];
    exp_t q_wr[$];
    exp_t q_rd[$];

    always #5 clk = ~clk;

    gray_ptr_sync_cmp #(.PTR_SZ(PTR_SZ), .SYNC_STAGES(S), .MODE(0), .ALMOST_TH(ATH)) u_wr (
        .clk(clk), .rst(rst), .remote_ptr_gray(remote), .local_ptr_bin(local_b),
        .err_clr(err_clr), .sync_ptr_gray(w_sg), .sync_ptr_bin(w_sb), .level(w_lvl),
        .full(w_full), .empty(w_empty), .almost(w_almost), .sync_ready(w_ready),
        .gray_err(w_gerr), .ptr_err(w_perr)
    );

    gray_ptr_sync_cmp #(.PTR_SZ(PTR_SZ), .SYNC_STAGES(S), .MODE(1), .ALMOST_TH(ATH)) u_rd (
        .clk(clk), .rst(rst), .remote_ptr_gray(remote), .local_ptr_bin(local_b),
        .err_clr(err_clr), .sync_ptr_gray(r_sg), .sync_ptr_bin(r_sb), .level(r_lvl),
        .full(r_full), .empty(r_empty), .almost(r_almost), .sync_ready(r_ready),
        .gray_err(r_gerr), .ptr_err(r_perr)
    );

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & MASK;
    endfunction

    // Inverse by search: the binary value whose Gray code matches.
    function automatic int from_gray(input int g);
        for (int b = 0; b <= MASK; b++) begin
            if (to_gray(b) == g) return b;
        end
        return 0;
    endfunction

    function automatic int raw_of(input int mode, input int sb, input int loc);
        return (mode == 0) ? ((loc - sb) & MASK) : ((sb - loc) & MASK);
    endfunction

    function automatic exp_t expect_of(input int mode);
        exp_t e;
        bit   rdy;
        int   sb;
        int   raw;
        rdy = (edges >= S + 1);
        sb  = from_gray(hist[S]);
        raw = raw_of(mode, sb, int'(local_b));
        e.sg     = PW'(hist[S-1]);
        e.sb     = PW'(sb);
        e.lvl    = rdy ? PW'(raw) : '0;
        e.full   = (mode == 0) && (rdy ? (raw == DEPTH) : 1'b1);
        e.empty  = (mode == 1) && (rdy ? (raw == 0) : 1'b1);
        e.almost = !rdy ? 1'b1 : (mode == 0) ? (raw >= DEPTH - ATH) : (raw <= ATH);
        e.ready  = rdy;
        e.gerr   = gerr;
        e.perr   = perr[mode];
        return e;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back(0);
        edges   = 0;
        gerr    = 1'b0;
        perr[0] = 1'b0;
        perr[1] = 1'b0;
    endtask

    task automatic model_edge();
        bit rdy;
        bit gset;
        int sb;
        rdy  = (edges >= S + 1);
        sb   = from_gray(hist[S]);
        gset = rdy && ($countones(hist[S-1] ^ hist[S]) > 1);
        for (int m = 0; m < 2; m++) begin
            perr[m] = (rdy && (raw_of(m, sb, int'(local_b)) > DEPTH)) | (perr[m] & !err_clr);
        end
        gerr = gset | (gerr & !err_clr);
        hist.push_front(int'(remote));
        void'(hist.pop_back());
        if (edges < S + 1) edges++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input exp_t a);
        chk({tag, "_sync_gray"}, int'(a.sg), int'(e.sg));
        chk({tag, "_sync_bin"},  int'(a.sb), int'(e.sb));
        chk({tag, "_level"},     int'(a.lvl), int'(e.lvl));
        chk({tag, "_full"},      int'(a.full), int'(e.full));
        chk({tag, "_empty"},     int'(a.empty), int'(e.empty));
        chk({tag, "_almost"},    int'(a.almost), int'(e.almost));
        chk({tag, "_ready"},     int'(a.ready), int'(e.ready));
        chk({tag, "_gray_err"},  int'(a.gerr), int'(e.gerr));
        chk({tag, "_ptr_err"},   int'(a.perr), int'(e.perr));
    endtask

    // Drive at the falling edge, publish expectations, then let the model
    // take the rising edge if reset is released.
    task automatic step(input int g, input int loc, input bit clr, input bit rst_v);
        @(negedge clk);
        remote  = PW'(g);
        local_b = PW'(loc);
        err_clr = clr;
        rst     = rst_v;
        if (!rst_v) model_reset();
        #1;
        q_wr.push_back(expect_of(0));
        q_rd.push_back(expect_of(1));
        @(posedge clk);
        if (rst) model_edge();
    endtask

    // Monitor: one set of outputs per cycle, compared against the queued
    // expectation, independent of the stimulus process.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            #2;
            if (q_wr.size() > 0) begin
                e = q_wr.pop_front();
                a = '{w_sg, w_sb, w_lvl, w_full, w_empty, w_almost, w_ready, w_gerr, w_perr};
                cmp("wr", e, a);
            end
            if (q_rd.size() > 0) begin
                e = q_rd.pop_front();
                a = '{r_sg, r_sb, r_lvl, r_full, r_empty, r_almost, r_ready, r_gerr, r_perr};
                cmp("rd", e, a);
            end
        end
    end

    initial begin
        int rb;
        int g;
        model_reset();

        // Warm-up with remote Gray 110 held.
        step(3'b110, 0, 0, 0);
        step(3'b110, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(3'b110, 0, 0, 1);
        #1;
        chk("warmup_bin", int'(w_sb), 4);
        chk("warmup_ready", int'(w_ready), 1);

        // Full with wrap, then one remote step.
        for (int i = 0; i < 4; i++) step(3'b111, 1, 0, 1);
        #1;
        chk("wrap_full_level", int'(w_lvl), 4);
        chk("wrap_full", int'(w_full), 1);
        for (int i = 0; i < 4; i++) step(3'b101, 1, 0, 1);
        #1;
        chk("wrap_step_level", int'(w_lvl), 3);
        step(3'b101, 1, 1, 1);

        // Empty on the read side, then one write.
        for (int i = 0; i < 4; i++) step(3'b101, 6, 0, 1);
        #1;
        chk("rd_empty", int'(r_empty), 1);
        for (int i = 0; i < 4; i++) step(3'b100, 6, 0, 1);
        #1;
        chk("rd_level1", int'(r_lvl), 1);
        step(3'b100, 7, 1, 1);

        // Gray violation, clear, and clear coinciding with a new violation.
        for (int i = 0; i < 4; i++) step(3'b000, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(3'b011, 2, 0, 1);
        #1;
        chk("gray_err_set", int'(w_gerr), 1);
        step(3'b011, 2, 1, 1);
        step(3'b011, 2, 0, 1);
        step(3'b000, 3, 0, 1);
        step(3'b000, 3, 0, 1);
        step(3'b000, 3, 1, 1);
        step(3'b000, 3, 0, 1);
        #1;
        chk("gray_err_set_wins", int'(w_gerr), 1);
        step(3'b000, 3, 1, 1);

        // Impossible level: sync bin 0, local 5.
        for (int i = 0; i < 4; i++) step(3'b000, 5, 0, 1);
        for (int i = 0; i < 3; i++) step(3'b000, 2, 0, 1);
        #1;
        chk("ptr_err_sticky", int'(w_perr), 1);
        step(3'b000, 2, 1, 1);

        // Steady level 2, reset mid-run, release.
        for (int i = 0; i < 3; i++) step(3'b000, 2, 0, 1);
        step(3'b000, 2, 0, 0);
        step(3'b000, 2, 0, 0);
        for (int i = 0; i < 5; i++) step(3'b000, 2, 0, 1);

        // Randomized: mostly legal single increments, occasional jumps,
        // random local pointer, random clears and rare resets.
        rb = 0;
        for (int n = 0; n < 400; n++) begin
            g = to_gray(rb);
            case ($urandom_range(0, 15))
                0, 1, 2, 3, 4, 5: begin rb = (rb + 1) & MASK; g = to_gray(rb); end
                15: begin g = int'($urandom_range(0, MASK)); rb = from_gray(g); end
                default: ;
            endcase
            step(g, int'($urandom_range(0, MASK)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 79) != 0));
        end

        repeat (2) @(negedge clk);
        #3;
        chk("queue_drained", q_wr.size() + q_rd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
